// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter sharing one APB master port between NUM_REQ single-beat
// command requesters, with a PREADY timeout and an id-tagged response channel.
module apb_master_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256,
    localparam int SW  = DATA_WIDTH / 8,
    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                           aclk,
    input  logic                           areset,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ-1:0]             req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
    input  logic [NUM_REQ*SW-1:0]          req_strb,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [IDW-1:0]                 rsp_id,
    output logic [DATA_WIDTH-1:0]          rsp_rdata,
    output logic                           rsp_error,
    output logic                           rsp_timeout,
    output logic                           PSEL,
    output logic                           PENABLE,
    output logic                           PWRITE,
    output logic [ADDR_WIDTH-1:0]          PADDR,
    output logic [DATA_WIDTH-1:0]          PWDATA,
    output logic [SW-1:0]                  PSTRB,
    input  logic [DATA_WIDTH-1:0]          PRDATA,
    input  logic                           PREADY,
    input  logic                           PSLVERR
);

    localparam int  CW      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int  TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam bit  TO_EN   = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2, RESP = 2'd3} state_t;

    state_t                state_r, state_n_s;
    logic [IDW-1:0]        last_grant_r;
    logic                  cmd_write_r;
    logic [ADDR_WIDTH-1:0] cmd_addr_r;
    logic [DATA_WIDTH-1:0] cmd_wdata_r;
    logic [SW-1:0]         cmd_strb_r;
    logic [CW-1:0]         cnt_r;
    logic [DATA_WIDTH-1:0] rsp_rdata_r;
    logic                  rsp_error_r;
    logic                  rsp_timeout_r;

    logic                  grant_found_s;
    logic [IDW-1:0]        grant_idx_s;
    logic [NUM_REQ-1:0]    req_ready_s;
    logic                  latch_s;
    logic                  done_s;
    logic                  timeout_s;
    logic                  psel_s;
    logic                  penable_s;
    logic                  resp_s;

    // Round-robin search upward from last_grant+1; the descending loop lets the nearest requester win.
    always_comb begin
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (req_valid[(int'(last_grant_r) + k) % NUM_REQ]) begin
                grant_found_s = 1'b1;
                grant_idx_s   = IDW'((int'(last_grant_r) + k) % NUM_REQ);
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    // Next-state decode and per-state control strobes.
    always_comb begin
        state_n_s   = state_r;
        req_ready_s = '0;
        latch_s     = 1'b0;
        done_s      = 1'b0;
        timeout_s   = 1'b0;
        case (state_r)
            IDLE: begin
                // Holding ready low during reset keeps a requester from seeing a phantom accept.
                if (grant_found_s && !areset) begin
                    req_ready_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_idx_s;
                    latch_s     = 1'b1;
                    state_n_s   = SETUP;
                end else begin
                    state_n_s = IDLE;
                end
            end
            SETUP: begin
                state_n_s = ACCESS;
            end
            ACCESS: begin
                if (PREADY) begin
                    done_s    = 1'b1;
                    state_n_s = RESP;
                end else if (TO_EN && (cnt_r == CW'(TO_LAST))) begin
                    timeout_s = 1'b1;
                    state_n_s = RESP;
                end else begin
                    state_n_s = ACCESS;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_n_s = IDLE;
                end else begin
                    state_n_s = RESP;
                end
            end
            default: begin
                state_n_s = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_n_s;
        end
    end

    // Command latch, arbitration pointer, access-phase counter and response capture.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            last_grant_r  <= IDW'(NUM_REQ - 1);
            cmd_write_r   <= 1'b0;
            cmd_addr_r    <= '0;
            cmd_wdata_r   <= '0;
            cmd_strb_r    <= '0;
            cnt_r         <= '0;
            rsp_rdata_r   <= '0;
            rsp_error_r   <= 1'b0;
            rsp_timeout_r <= 1'b0;
        end else begin
            if (latch_s) begin
                last_grant_r <= grant_idx_s;
                cmd_write_r  <= req_write[grant_idx_s];
                cmd_addr_r   <= req_addr[int'(grant_idx_s)*ADDR_WIDTH +: ADDR_WIDTH];
                cmd_wdata_r  <= req_wdata[int'(grant_idx_s)*DATA_WIDTH +: DATA_WIDTH];
                cmd_strb_r   <= req_strb[int'(grant_idx_s)*SW +: SW];
            end
            if (state_r == SETUP) begin
                cnt_r <= '0;
            end else if (state_r == ACCESS) begin
                cnt_r <= cnt_r + CW'(1);
            end
            if (done_s) begin
                rsp_rdata_r   <= cmd_write_r ? '0 : PRDATA;
                rsp_error_r   <= PSLVERR;
                rsp_timeout_r <= 1'b0;
            end else if (timeout_s) begin
                rsp_rdata_r   <= '0;
                rsp_error_r   <= 1'b1;
                rsp_timeout_r <= 1'b1;
            end
        end
    end

    assign psel_s    = (state_r == SETUP) || (state_r == ACCESS);
    assign penable_s = (state_r == ACCESS);
    assign resp_s    = (state_r == RESP);

    assign req_ready   = req_ready_s;
    assign PSEL        = psel_s;
    assign PENABLE     = penable_s;
    assign PWRITE      = psel_s & cmd_write_r;
    assign PADDR       = psel_s ? cmd_addr_r : '0;
    assign PWDATA      = (psel_s && cmd_write_r) ? cmd_wdata_r : '0;
    assign PSTRB       = (psel_s && cmd_write_r) ? cmd_strb_r : '0;
    assign rsp_valid   = resp_s;
    assign rsp_id      = resp_s ? last_grant_r : '0;
    assign rsp_rdata   = rsp_rdata_r;
    assign rsp_error   = rsp_error_r;
    assign rsp_timeout = rsp_timeout_r;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed self-checking bench for apb_master_arbiter (4 requesters, timeout of 8).
module tb_apb_master_arbiter;

    logic         aclk;
    logic         areset;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [3:0]   req_write;
    logic [127:0] req_addr;
    logic [127:0] req_wdata;
    logic [15:0]  req_strb;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [1:0]   rsp_id;
    logic [31:0]  rsp_rdata;
    logic         rsp_error;
    logic         rsp_timeout;
    logic         PSEL;
    logic         PENABLE;
    logic         PWRITE;
    logic [31:0]  PADDR;
    logic [31:0]  PWDATA;
    logic [3:0]   PSTRB;
    logic [31:0]  PRDATA;
    logic         PREADY;
    logic         PSLVERR;

    int checks;
    int errors;

    apb_master_arbiter #(
        .NUM_REQ        (4),
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .aclk        (aclk),
        .areset      (areset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_strb    (req_strb),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_rdata   (rsp_rdata),
        .rsp_error   (rsp_error),
        .rsp_timeout (rsp_timeout),
        .PSEL        (PSEL),
        .PENABLE     (PENABLE),
        .PWRITE      (PWRITE),
        .PADDR       (PADDR),
        .PWDATA      (PWDATA),
        .PSTRB       (PSTRB),
        .PRDATA      (PRDATA),
        .PREADY      (PREADY),
        .PSLVERR     (PSLVERR)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge aclk);
    endtask

    initial begin
        logic [31:0] addr_tab [4];
        logic [31:0] data_tab [4];
        logic [3:0]  exp_rdy;
        int          exp_id;
        int          n;

        addr_tab = '{32'h0000_0100, 32'h0000_0104, 32'h0000_0108, 32'h0000_010C};
        data_tab = '{32'hA0A0_0000, 32'hA0A0_0001, 32'hA0A0_0002, 32'hA0A0_0003};
        checks    = 0;
        errors    = 0;
        areset    = 1'b1;
        req_valid = 4'b0000;
        req_write = 4'b0000;
        req_addr  = '0;
        req_wdata = '0;
        req_strb  = '0;
        rsp_ready = 1'b1;
        PRDATA    = 32'h0;
        PREADY    = 1'b0;
        PSLVERR   = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_psel", PSEL, 1'b0);
        chk("rst_penable", PENABLE, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_req_ready", req_ready, 4'b0000);
        chk("rst_paddr", PADDR, 32'h0);
        chk("rst_rsp_id", rsp_id, 2'd0);

        // Single read from requester 0, zero wait states
        areset            = 1'b0;
        req_valid         = 4'b0001;
        req_addr[31:0]    = 32'h0000_0040;
        PRDATA            = 32'hDEAD_BEEF;
        PREADY            = 1'b1;
        #1;
        chk("t1_grant", req_ready, 4'b0001);
        chk("t1_psel_T", PSEL, 1'b0);
        tick();
        req_valid = 4'b0000;
        chk("t1_psel_T1", PSEL, 1'b1);
        chk("t1_penable_T1", PENABLE, 1'b0);
        chk("t1_paddr", PADDR, 32'h0000_0040);
        chk("t1_pwrite", PWRITE, 1'b0);
        chk("t1_pwdata_rd", PWDATA, 32'h0);
        tick();
        chk("t1_psel_T2", PSEL, 1'b1);
        chk("t1_penable_T2", PENABLE, 1'b1);
        tick();
        chk("t1_rsp_valid", rsp_valid, 1'b1);
        chk("t1_rsp_id", rsp_id, 2'd0);
        chk("t1_rdata", rsp_rdata, 32'hDEAD_BEEF);
        chk("t1_error", rsp_error, 1'b0);
        chk("t1_psel_resp", PSEL, 1'b0);
        tick();
        chk("t1_rsp_done", rsp_valid, 1'b0);

        // All four requesters writing continuously: 0,1,2,3,0 at 4-cycle spacing
        areset = 1'b1;
        #2;
        areset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req_addr[i*32 +: 32]  = addr_tab[i];
            req_wdata[i*32 +: 32] = data_tab[i];
            req_strb[i*4 +: 4]    = 4'b0001 << i;
        end
        req_write = 4'b1111;
        req_valid = 4'b1111;
        #1;
        for (int i = 0; i < 5; i++) begin
            exp_id  = i % 4;
            exp_rdy = 4'b0001 << exp_id;
            chk("t2_grant", req_ready, exp_rdy);
            tick();
            if (i == 4) begin
                req_valid = 4'b0000;
            end
            chk("t2_paddr", PADDR, addr_tab[exp_id]);
            chk("t2_pwdata", PWDATA, data_tab[exp_id]);
            chk("t2_pstrb", PSTRB, exp_rdy);
            chk("t2_pwrite", PWRITE, 1'b1);
            tick();
            tick();
            chk("t2_rsp_id", rsp_id, exp_id);
            tick();
        end
        chk("t2_idle_ready", req_ready, 4'b0000);

        // Requester 2 write, 3 wait states then PSLVERR
        req_addr[64 +: 32]  = 32'h0000_0200;
        req_wdata[64 +: 32] = 32'h0000_55AA;
        PREADY    = 1'b0;
        req_valid = 4'b0100;
        #1;
        chk("t3_grant", req_ready, 4'b0100);
        tick();
        req_valid = 4'b0000;
        chk("t3_paddr", PADDR, 32'h0000_0200);
        chk("t3_pwdata", PWDATA, 32'h0000_55AA);
        tick();
        n = 0;
        while (PENABLE === 1'b1 && n < 40) begin
            n++;
            if (n == 4) begin
                PREADY  = 1'b1;
                PSLVERR = 1'b1;
            end
            tick();
        end
        chk("t3_access_len", n, 4);
        chk("t3_rsp_valid", rsp_valid, 1'b1);
        chk("t3_error", rsp_error, 1'b1);
        chk("t3_timeout", rsp_timeout, 1'b0);
        chk("t3_rsp_id", rsp_id, 2'd2);
        chk("t3_rdata_wr", rsp_rdata, 32'h0);
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
        tick();

        // Requester 3 read with PREADY stuck low: timeout after 8 ACCESS cycles
        req_addr[96 +: 32] = 32'h0000_0300;
        req_write          = 4'b0000;
        PRDATA             = 32'h1234_5678;
        req_valid          = 4'b1000;
        #1;
        chk("t4_grant", req_ready, 4'b1000);
        tick();
        req_valid = 4'b0000;
        chk("t4_pwdata_rd", PWDATA, 32'h0);
        chk("t4_pstrb_rd", PSTRB, 4'b0000);
        tick();
        n = 0;
        while (PENABLE === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        chk("t4_access_len", n, 8);
        chk("t4_psel_drop", PSEL, 1'b0);
        chk("t4_rsp_valid", rsp_valid, 1'b1);
        chk("t4_error", rsp_error, 1'b1);
        chk("t4_timeout", rsp_timeout, 1'b1);
        chk("t4_rdata", rsp_rdata, 32'h0);
        chk("t4_rsp_id", rsp_id, 2'd3);
        tick();

        // Response back-pressure for 5 cycles with requesters 1 and 3 pending
        rsp_ready = 1'b0;
        PREADY    = 1'b1;
        PRDATA    = 32'hCAFE_0001;
        req_valid = 4'b1010;
        #1;
        chk("t5_grant", req_ready, 4'b0010);
        tick();
        tick();
        tick();
        chk("t5_rsp_valid", rsp_valid, 1'b1);
        chk("t5_rsp_id", rsp_id, 2'd1);
        chk("t5_rdata", rsp_rdata, 32'hCAFE_0001);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t5_hold_valid", rsp_valid, 1'b1);
            chk("t5_hold_id", rsp_id, 2'd1);
            chk("t5_hold_rdata", rsp_rdata, 32'hCAFE_0001);
            chk("t5_no_grant", req_ready, 4'b0000);
        end
        rsp_ready = 1'b1;
        tick();
        chk("t5_rsp_done", rsp_valid, 1'b0);
        chk("t5_next_grant", req_ready, 4'b1000);

        // Reset during ACCESS
        PREADY = 1'b0;
        tick();
        chk("t6_setup", PSEL, 1'b1);
        tick();
        chk("t6_access", PENABLE, 1'b1);
        #2;
        areset = 1'b1;
        #1;
        chk("t6_psel_async", PSEL, 1'b0);
        chk("t6_penable_async", PENABLE, 1'b0);
        chk("t6_ready_rst", req_ready, 4'b0000);
        tick();
        tick();
        chk("t6_no_rsp", rsp_valid, 1'b0);
        req_valid = 4'b0011;
        areset    = 1'b0;
        #1;
        chk("t6_ptr_reset", req_ready, 4'b0001);
        req_valid = 4'b0000;
        tick();
        chk("t6_no_rsp_after", rsp_valid, 1'b0);
        chk("t6_idle_after", PSEL, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
